alu_decode: RTL and testbench

Pipelined decode stage for the Eka core. It accepts a 32-bit RV32I instruction over a valid/ready handshake and produces the registered control bundle that drives the ALU: the 4-bit `ALU_Ctrl` encoding, the operand-2 select, the sign-extended immediate, register indices and memory/branch flags. It sits between fetch and execute, and only emits `ALU_Ctrl` codes the ALU implements; every other instruction is flagged illegal.

---
 rtl/alu_pkg.sv | 59 +++++
 rtl/alu_decode_comb.sv | 101 ++++++++++
 rtl/alu_decode.sv | 133 +++++++++++++
 tb/tb_alu_decode.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the Eka decode stage.
//   - ALU_Ctrl operation codes understood by the execute-stage ALU
//   - RV32I opcode and funct3 constants used by the decoder
//   - alu_decode_t: the registered control bundle handed to execute
//   - helpers mapping the arithmetic funct3 field onto an ALU code
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b0100;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef struct packed {
    logic [3:0]  alu_ctrl;
    logic        src2_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        branch_ne;
    logic        illegal;
  } alu_decode_t;

  // Only ADD/XOR/OR/AND funct3 values have an ALU implementation;
  // shifts and compares are rejected as illegal.
  function automatic logic arith_f3_ok(input logic [2:0] f3);
    return (f3 == F3_ADD) || (f3 == F3_XOR) || (f3 == F3_OR) || (f3 == F3_AND);
  endfunction

  function automatic logic [3:0] arith_ctrl(input logic [2:0] f3);
    case (f3)
      F3_XOR:  return ALU_XOR;
      F3_OR:   return ALU_OR;
      F3_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// alu_decode_comb: purely combinational RV32I instruction -> alu_decode_t.
// Ports:
//   instr_i  in  32  instruction word
//   dec_o    out     decoded control bundle (alu_pkg::alu_decode_t)
// Unsupported encodings produce illegal=1 with ALU code ADD and every
// write/memory/branch flag cleared; register indices are always passed.
module alu_decode_comb
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  output alu_decode_t dec_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic        legal;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};

  always_comb begin
    dec_o     = '0;
    legal     = 1'b0;
    dec_o.rs1 = instr_i[19:15];
    dec_o.rs2 = instr_i[24:20];
    dec_o.rd  = instr_i[11:7];

    case (opcode)
      OPC_RTYPE: begin
        if (arith_f3_ok(funct3)) begin
          legal           = 1'b1;
          dec_o.reg_write = 1'b1;
          // funct7[5] (instr bit 30) selects SUB only for the ADD slot
          if (funct3 == F3_ADD && instr_i[30])
            dec_o.alu_ctrl = ALU_SUB;
          else
            dec_o.alu_ctrl = arith_ctrl(funct3);
        end
      end
      OPC_ITYPE: begin
        if (arith_f3_ok(funct3)) begin
          legal           = 1'b1;
          dec_o.alu_ctrl  = arith_ctrl(funct3);
          dec_o.src2_imm  = 1'b1;
          dec_o.imm       = imm_i;
          dec_o.reg_write = 1'b1;
        end
      end
      OPC_LOAD: begin
        if (funct3 == F3_LW) begin
          legal           = 1'b1;
          dec_o.alu_ctrl  = ALU_ADD;
          dec_o.src2_imm  = 1'b1;
          dec_o.imm       = imm_i;
          dec_o.mem_read  = 1'b1;
          dec_o.reg_write = 1'b1;
        end
      end
      OPC_STORE: begin
        if (funct3 == F3_SW) begin
          legal           = 1'b1;
          dec_o.alu_ctrl  = ALU_ADD;
          dec_o.src2_imm  = 1'b1;
          dec_o.imm       = imm_s;
          dec_o.mem_write = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
          legal           = 1'b1;
          dec_o.alu_ctrl  = ALU_SUB;
          dec_o.imm       = imm_b;
          dec_o.branch    = 1'b1;
          dec_o.branch_ne = (funct3 == F3_BNE);
        end
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec_o.alu_ctrl  = ALU_ADD;
      dec_o.src2_imm  = 1'b0;
      dec_o.imm       = '0;
      dec_o.reg_write = 1'b0;
      dec_o.mem_read  = 1'b0;
      dec_o.mem_write = 1'b0;
      dec_o.branch    = 1'b0;
      dec_o.branch_ne = 1'b0;
      dec_o.illegal   = 1'b1;
    end
  end

endmodule

// File: rtl/alu_decode.sv
// alu_decode: registered decode stage between fetch and execute.
// Ports:
//   clk, reset (async, active-high), flush (sync kill)
//   in_valid/in_ready/in_instr       : instruction handshake from fetch
//   out_valid/out_ready              : bundle handshake to execute
//   out_alu_ctrl, out_src2_imm, out_imm, out_rs1/rs2/rd,
//   out_reg_write, out_mem_read, out_mem_write, out_branch,
//   out_branch_ne, out_illegal       : registered control bundle
// Build option ALU_DECODE_SKID_EN: adds a skid entry so in_ready comes
// straight from a register; otherwise in_ready is combinational.
module alu_decode
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_alu_ctrl,
  output logic        out_src2_imm,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        out_branch,
  output logic        out_branch_ne,
  output logic        out_illegal
);

  alu_decode_t dec;
  alu_decode_t out_q, out_d;
  logic        out_valid_q, out_valid_d;
  logic        accept;
  logic        consume;

  alu_decode_comb u_comb (
    .instr_i (in_instr),
    .dec_o   (dec)
  );

  assign accept  = in_valid && in_ready;
  assign consume = out_valid_q && out_ready;

`ifdef ALU_DECODE_SKID_EN
  alu_decode_t skid_q, skid_d;
  logic        skid_valid_q, skid_valid_d;

  assign in_ready = !skid_valid_q;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || consume) begin
      // Output slot frees up: the parked entry goes first to keep order.
      // No accept can coincide with a full skid since in_ready is low.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_d       = dec;
      out_valid_d = 1'b1;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_alu_ctrl  = out_q.alu_ctrl;
  assign out_src2_imm  = out_q.src2_imm;
  assign out_imm       = out_q.imm;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_rd        = out_q.rd;
  assign out_reg_write = out_q.reg_write;
  assign out_mem_read  = out_q.mem_read;
  assign out_mem_write = out_q.mem_write;
  assign out_branch    = out_q.branch;
  assign out_branch_ne = out_q.branch_ne;
  assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_decode.sv
module tb_alu_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_ctrl;
  logic        out_src2_imm;
  logic [31:0] out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_reg_write, out_mem_read, out_mem_write;
  logic        out_branch, out_branch_ne, out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_decode dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_alu_ctrl  (out_alu_ctrl),
    .out_src2_imm  (out_src2_imm),
    .out_imm       (out_imm),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_rd        (out_rd),
    .out_reg_write (out_reg_write),
    .out_mem_read  (out_mem_read),
    .out_mem_write (out_mem_write),
    .out_branch    (out_branch),
    .out_branch_ne (out_branch_ne),
    .out_illegal   (out_illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // flags = {reg_write, mem_read, mem_write, branch, branch_ne, illegal}
  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [3:0]  alu;
    logic        s2;
    logic [31:0] imm;
    logic        chk_imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [5:0]  flags;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [5:0] out_flags();
    return {out_reg_write, out_mem_read, out_mem_write, out_branch, out_branch_ne, out_illegal};
  endfunction

`ifdef ALU_DECODE_SKID_EN
  localparam int EXP_ACC = 2;
`else
  localparam int EXP_ACC = 1;
`endif

  logic [31:0] bp[4];
  logic [4:0]  got[$];
  int          idx;
  int          seen;

  initial begin
    vecs[0]  = '{"add",    32'h002081B3, 4'b0000, 1'b0, 32'h0,        1'b1, 5'd1, 5'd2,  5'd3,  6'b100000};
    vecs[1]  = '{"sub",    32'h402081B3, 4'b1000, 1'b0, 32'h0,        1'b1, 5'd1, 5'd2,  5'd3,  6'b100000};
    vecs[2]  = '{"addi",   32'hFFF00093, 4'b0000, 1'b1, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd31, 5'd1,  6'b100000};
    vecs[3]  = '{"beq",    32'hFE208EE3, 4'b1000, 1'b0, 32'hFFFFFFFC, 1'b1, 5'd1, 5'd2,  5'd29, 6'b000100};
    vecs[4]  = '{"bne",    32'hFE209EE3, 4'b1000, 1'b0, 32'hFFFFFFFC, 1'b1, 5'd1, 5'd2,  5'd29, 6'b000110};
    vecs[5]  = '{"sll",    32'h002091B3, 4'b0000, 1'b0, 32'h0,        1'b0, 5'd1, 5'd2,  5'd3,  6'b000001};
    vecs[6]  = '{"lw",     32'h0040A183, 4'b0000, 1'b1, 32'h4,        1'b1, 5'd1, 5'd4,  5'd3,  6'b110000};
    vecs[7]  = '{"sw",     32'hFE20AC23, 4'b0000, 1'b1, 32'hFFFFFFF8, 1'b1, 5'd1, 5'd2,  5'd24, 6'b001000};
    vecs[8]  = '{"ori",    32'h7FF36293, 4'b0110, 1'b1, 32'h000007FF, 1'b1, 5'd6, 5'd31, 5'd5,  6'b100000};
    vecs[9]  = '{"and",    32'h009473B3, 4'b0111, 1'b0, 32'h0,        1'b1, 5'd8, 5'd9,  5'd7,  6'b100000};
    vecs[10] = '{"xori",   32'h80014093, 4'b0100, 1'b1, 32'hFFFFF800, 1'b1, 5'd2, 5'd0,  5'd1,  6'b100000};
    vecs[11] = '{"lui",    32'h000010B7, 4'b0000, 1'b0, 32'h0,        1'b0, 5'd0, 5'd0,  5'd1,  6'b000001};
    vecs[12] = '{"lb",     32'h00408183, 4'b0000, 1'b0, 32'h0,        1'b0, 5'd1, 5'd4,  5'd3,  6'b000001};

    for (int i = 0; i < 4; i++) bp[i] = 32'h00208033 | (32'(i + 1) << 7);

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_imm", out_imm, 32'd0);
    chk("reset_rd", 32'(out_rd), 32'd0);
    chk("reset_flags", 32'(out_flags()), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    chk("post_reset_out_valid", 32'(out_valid), 32'd0);

    // Decode table: accept at one edge, bundle visible right after it.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      in_instr = vecs[i].instr; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk({vecs[i].name, "_in_ready"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk({vecs[i].name, "_out_valid"}, 32'(out_valid), 32'd1);
      chk({vecs[i].name, "_alu_ctrl"}, 32'(out_alu_ctrl), 32'(vecs[i].alu));
      chk({vecs[i].name, "_rs1"}, 32'(out_rs1), 32'(vecs[i].rs1));
      chk({vecs[i].name, "_rs2"}, 32'(out_rs2), 32'(vecs[i].rs2));
      chk({vecs[i].name, "_rd"}, 32'(out_rd), 32'(vecs[i].rd));
      chk({vecs[i].name, "_flags"}, 32'(out_flags()), 32'(vecs[i].flags));
      if (vecs[i].chk_imm) begin
        chk({vecs[i].name, "_src2_imm"}, 32'(out_src2_imm), 32'(vecs[i].s2));
        chk({vecs[i].name, "_imm"}, out_imm, vecs[i].imm);
      end
    end
    @(negedge clk);
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    // Backpressure: four instructions, output stalled for three cycles.
    idx = 0;
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      @(negedge clk);
      out_ready = (c >= 3);
      in_valid  = (idx < 4);
      in_instr  = bp[(idx < 4) ? idx : 0];
      #1;
      if (c == 2) begin
        chk("bp_in_ready_stall", 32'(in_ready), 32'd0);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_rd", 32'(out_rd), 32'd1);
      end
      if (c == 3) chk("bp_accepted_during_stall", 32'(idx), 32'(EXP_ACC));
      if (out_valid && out_ready) got.push_back(out_rd);
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0;
    chk("bp_delivered_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) chk("bp_order", 32'(got[i]), 32'(i + 1));
    @(negedge clk);
    @(negedge clk);
    chk("bp_no_duplicate", 32'(out_valid), 32'd0);

    // Flush while stalled with the stage full, new instruction offered.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = vecs[0].instr;
    @(negedge clk);
    in_instr = vecs[9].instr;
    @(negedge clk);
    flush = 1'b1; in_instr = vecs[8].instr;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_nothing_delivered", 32'(seen), 32'd0);

    // Flush on an empty stage beats an incoming handshake.
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_instr = vecs[2].instr;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_kills_input", 32'(out_valid), 32'd0);

    // Reset asserted mid-stall clears outputs without waiting for a clock.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = vecs[8].instr;
    @(negedge clk);
    in_instr = vecs[9].instr;
    @(negedge clk);
    in_valid = 1'b0;
    chk("stall_before_reset", 32'(out_valid), 32'd1);
    chk("stall_before_reset_rd", 32'(out_rd), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_imm", out_imm, 32'd0);
    chk("midreset_ctrl", 32'(out_alu_ctrl), 32'd0);
    chk("midreset_regs", 32'({out_rs1, out_rs2, out_rd}), 32'd0);
    chk("midreset_flags", 32'({out_src2_imm, out_flags()}), 32'd0);
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midreset_in_ready", 32'(in_ready), 32'd1);
    chk("midreset_nothing_delivered", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
